// File: rtl/y86_seq_ctrl.sv
// Y86-64 SEQ sequencer: steps FETCH..PCUPD one stage per clock, owns PC and status.
// Optional retired-instruction counter enabled by defining Y86_PERF_CNT_EN.
module y86_seq_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              instr_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic              imem_error,
  input  logic              cnd,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valM,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic [3:0]        icode_q,
  output logic [3:0]        ifun_q,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stat,
`ifdef Y86_PERF_CNT_EN
  output logic [31:0]       retired,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t            state_q, state_d;
  logic [2:0]        stat_d;
  logic [ADDR_W-1:0] pc_d;
  logic              cnd_q;
  logic              mem_acc;
  logic              wb_wr;

  always_comb begin
    mem_acc = (icode_q == 4'd4) || (icode_q == 4'd5) || (icode_q == 4'd8) ||
              (icode_q == 4'd9) || (icode_q == 4'd10) || (icode_q == 4'd11);
    wb_wr   = (icode_q == 4'd3) || (icode_q == 4'd5) || (icode_q == 4'd6) ||
              (icode_q == 4'd8) || (icode_q == 4'd9) || (icode_q == 4'd10) ||
              (icode_q == 4'd11) || ((icode_q == 4'd2) && cnd_q);
    state_d = state_q;
    stat_d  = stat;
    pc_d    = pc;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        // Address fault outranks an undecodable instruction.
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid || (icode > 4'd11)) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'd0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        if (mem_en && dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if (((icode_q == 4'd7) && cnd_q) || (icode_q == 4'd8)) pc_d = valC;
        else if (icode_q == 4'd9)                              pc_d = valM;
        else                                                   pc_d = valP;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Enables are registered from the next state so each is a clean Moore output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc        <= RESET_PC;
      stat      <= STAT_AOK;
      icode_q   <= 4'd0;
      ifun_q    <= 4'd0;
      cnd_q     <= 1'b0;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      busy      <= 1'b0;
`ifdef Y86_PERF_CNT_EN
      retired   <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      stat      <= stat_d;
      if (state_q == S_FETCH) begin
        icode_q <= icode;
        ifun_q  <= ifun;
      end
      if (state_q == S_EXECUTE) cnd_q <= cnd;
      fetch_en  <= (state_d == S_FETCH);
      decode_en <= (state_d == S_DECODE);
      exec_en   <= (state_d == S_EXECUTE);
      mem_en    <= (state_d == S_MEMORY) && mem_acc;
      wb_en     <= (state_d == S_WRITEBACK) && wb_wr;
      busy      <= (state_d != S_IDLE) && (state_d != S_HALT);
`ifdef Y86_PERF_CNT_EN
      if ((state_q == S_PCUPD) && (retired != 32'hFFFF_FFFF))
        retired <= retired + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed plus random bench for y86_seq_ctrl against an instruction-level reference model.
module tb_y86_seq_ctrl;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          instr_valid = 1'b1;
  logic [3:0]    icode = 4'd0;
  logic [3:0]    ifun = 4'd0;
  logic          imem_error = 1'b0;
  logic          cnd = 1'b0;
  logic          dmem_error = 1'b0;
  logic [AW-1:0] valC = '0;
  logic [AW-1:0] valP = '0;
  logic [AW-1:0] valM = '0;
  logic          fetch_en, decode_en, exec_en, mem_en, wb_en, busy;
  logic [3:0]    icode_q, ifun_q;
  logic [AW-1:0] pc;
  logic [2:0]    stat;
`ifdef Y86_PERF_CNT_EN
  logic [31:0]   retired;
`endif

  y86_seq_ctrl #(.ADDR_W(AW), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid),
    .icode(icode), .ifun(ifun), .imem_error(imem_error), .cnd(cnd),
    .dmem_error(dmem_error), .valC(valC), .valP(valP), .valM(valM),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .icode_q(icode_q), .ifun_q(ifun_q),
    .pc(pc), .stat(stat),
`ifdef Y86_PERF_CNT_EN
    .retired(retired),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural state at instruction granularity.
  logic [63:0] pc_m;
  logic [2:0]  stat_m;
  bit          halted_m;
  longint unsigned retired_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit uses_mem(input logic [3:0] ic);
    return ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic bit writes_reg(input logic [3:0] ic, input logic c);
    return (ic inside {4'd3, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) || (ic == 4'd2 && c);
  endfunction

  // Expected {fetch,decode,exec,mem,wb} for the k-th clock of an instruction.
  function automatic logic [4:0] stage_en(input int k, input logic [3:0] ic, input logic c);
    case (k)
      0:       return 5'b10000;
      1:       return 5'b01000;
      2:       return 5'b00100;
      3:       return {3'b000, uses_mem(ic), 1'b0};
      4:       return {4'b0000, writes_reg(ic, c)};
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [63:0] next_pc(input logic [3:0] ic, input logic c,
                                          input logic [63:0] vc, input logic [63:0] vp,
                                          input logic [63:0] vm);
    if ((ic == 4'd7 && c) || ic == 4'd8) return vc;
    if (ic == 4'd9) return vm;
    return vp;
  endfunction

  task automatic check_outputs(input string tag, input logic [4:0] en, input logic b);
    check({tag, "_en"}, {59'd0, fetch_en, decode_en, exec_en, mem_en, wb_en}, {59'd0, en});
    check({tag, "_busy"}, {63'd0, busy}, {63'd0, b});
    check({tag, "_pc"}, pc, pc_m);
    check({tag, "_stat"}, {61'd0, stat}, {61'd0, stat_m});
  endtask

  task automatic check_retired(input string tag);
`ifdef Y86_PERF_CNT_EN
    check({tag, "_retired"}, {32'd0, retired}, retired_m);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Called at a negedge; asserts rst asynchronously mid-cycle and releases at the next negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    start = 1'b0;
    pc_m = 64'h0; stat_m = 3'd1; halted_m = 1'b0; retired_m = 0;
    #1;
    check_outputs("reset", 5'b00000, 1'b0);
    check("reset_icode_q", {60'd0, icode_q}, 64'd0);
    check("reset_ifun_q", {60'd0, ifun_q}, 64'd0);
    check_retired("reset");
    @(negedge clk);
    rst = 1'b0;
    $display("reset released pc=0x%0h", pc);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge where FETCH is expected; leaves at the next FETCH negedge or in HALT.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ifn, input logic iv,
                           input logic ie, input logic c, input logic de,
                           input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm);
    int halt_at;
    int last;
    logic [2:0] hstat;
    icode = ic; ifun = ifn; instr_valid = iv; imem_error = ie;
    cnd = c; dmem_error = de; valC = vc; valP = vp; valM = vm;
    halt_at = 6; hstat = 3'd1;
    if (ie)                       begin halt_at = 1; hstat = 3'd3; end
    else if (!iv || ic > 4'd11)   begin halt_at = 1; hstat = 3'd4; end
    else if (ic == 4'd0)          begin halt_at = 1; hstat = 3'd2; end
    else if (uses_mem(ic) && de)  begin halt_at = 4; hstat = 3'd3; end
    last = (halt_at < 6) ? halt_at : 5;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      if (k == halt_at) begin
        stat_m = hstat;
        check_outputs($sformatf("halt_ic%0d", ic), 5'b00000, 1'b0);
      end else begin
        check_outputs($sformatf("ic%0d_k%0d", ic, k), stage_en(k, ic, c), 1'b1);
      end
      if (k == 1) begin
        check("icode_q", {60'd0, icode_q}, {60'd0, ic});
        check("ifun_q", {60'd0, ifun_q}, {60'd0, ifn});
      end
    end
    start = 1'b0;
    if (halt_at < 6) begin
      halted_m = 1'b1;
    end else begin
      @(negedge clk);
      pc_m = next_pc(ic, c, vc, vp, vm);
      if (retired_m < 64'hFFFF_FFFF) retired_m++;
      check_outputs($sformatf("next_fetch_ic%0d", ic), 5'b10000, 1'b1);
    end
    check_retired("instr");
    $display("instr icode=%0d ifun=%0d cnd=%0b pc=0x%0h stat=%0d", ic, ifn, c, pc, stat);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'(i % 2 == 0);
      @(negedge clk);
      check_outputs("halt_hold", 5'b00000, 1'b0);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] ric;
    logic       riv, rie, rde;
    int         r;

    @(negedge clk);
    do_reset();
    start_pulse();
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h1, 64'h0);
    run_instr(4'd7, 4'd1, 1, 0, 1, 0, 64'h40, 64'h9, 64'h0);
    run_instr(4'd7, 4'd1, 1, 0, 0, 0, 64'h80, 64'h9, 64'h0);
    run_instr(4'd9, 4'd0, 1, 0, 0, 0, 64'h0, 64'h11, 64'h100);
    run_instr(4'd2, 4'd0, 1, 0, 0, 0, 64'h0, 64'h102, 64'h0);
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h20, 64'h0);
    run_instr(4'd0, 4'd0, 1, 0, 0, 0, 64'h0, 64'h21, 64'h0);
    halt_hold(4);

    do_reset();
    start_pulse();
    run_instr(4'd12, 4'd0, 1, 0, 0, 0, 64'h0, 64'h2, 64'h0);
    halt_hold(2);
    do_reset();
    start_pulse();
    run_instr(4'd3, 4'd0, 0, 1, 0, 0, 64'h0, 64'ha, 64'h0);
    halt_hold(2);
    do_reset();
    start_pulse();
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h30, 64'h0);
    run_instr(4'd5, 4'd0, 1, 0, 1, 1, 64'h8, 64'h3a, 64'h0);
    halt_hold(2);

    // Abort mid-EXECUTE, then confirm a clean restart.
    do_reset();
    start_pulse();
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h30, 64'h0);
    icode = 4'd6; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_exec_en", {63'd0, exec_en}, 64'd1);
    do_reset();
    start_pulse();
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h4, 64'h0);
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'h8, 64'h0);
    run_instr(4'd1, 4'd0, 1, 0, 0, 0, 64'h0, 64'hc, 64'h0);

    for (int i = 0; i < 80; i++) begin
      if (halted_m) begin
        do_reset();
        start_pulse();
      end
      r   = int'($urandom_range(0, 99));
      rie = (r < 3);
      riv = !(r >= 3 && r < 6);
      if (r >= 6 && r < 9)        ric = 4'(12 + (r - 6));
      else if (r == 9)            ric = 4'd0;
      else                        ric = 4'($urandom_range(1, 11));
      rde = ($urandom_range(0, 14) == 0);
      run_instr(ric, 4'($urandom_range(0, 15)), riv, rie, 1'($urandom_range(0, 1)), rde,
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
